// File: rtl/fifo_lane_serializer_if.sv
// Set-side and lane-side handshake bundle of the lane serializer.
// The master modport is the serializer; the slave modport is its surroundings.
interface fifo_lane_serializer_if #(
  parameter int unsigned N      = 8,
  parameter int unsigned LANE_W = 8,
  parameter int unsigned IDX_W  = $clog2(N)
);
  logic [N*LANE_W-1:0] set_data;
  logic                set_empty;
  logic                set_rd_en;
  logic                lane_valid;
  logic                lane_ready;
  logic [LANE_W-1:0]   lane_data;
  logic [IDX_W-1:0]    lane_idx;
  logic                lane_last;

  modport master (
    input  set_data,
    input  set_empty,
    output set_rd_en,
    output lane_valid,
    input  lane_ready,
    output lane_data,
    output lane_idx,
    output lane_last
  );

  modport slave (
    output set_data,
    output set_empty,
    input  set_rd_en,
    input  lane_valid,
    output lane_ready,
    input  lane_data,
    input  lane_idx,
    input  lane_last
  );
endinterface

// File: rtl/fifo_lane_serializer.sv
// Pops one N-lane set from an FWFT hold buffer and emits it lane by lane over valid/ready,
// with runtime lane count, selectable lane order and flush.
module fifo_lane_serializer #(
  parameter int unsigned N      = 8,
  parameter int unsigned LANE_W = 8,
  parameter int unsigned IDX_W  = $clog2(N),
  parameter int unsigned CNT_W  = $clog2(N + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  fifo_lane_serializer_if.master bus,
  input  logic [CNT_W-1:0]       i_lane_cnt,
  input  logic                   i_msb_first,
  input  logic                   i_flush,
  output logic                   o_busy,
  output logic [15:0]            o_set_count,
  output logic [15:0]            o_lane_count
);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e              state_q;
  logic [N*LANE_W-1:0] sreg_q;
  logic [CNT_W-1:0]    eff_q;
  logic [CNT_W-1:0]    emit_q;
  logic [IDX_W-1:0]    idx_q;
  logic                msb_q;
  logic                valid_q;
  logic                last_q;
  logic [15:0]         set_cnt_q;
  logic [15:0]         lane_cnt_q;

  logic             accept;
  logic             capture;
  logic [CNT_W-1:0] eff_cnt;
  logic [CNT_W-1:0] emit_nxt;
  logic             last_nxt;

  always_comb begin
    accept  = valid_q & bus.lane_ready;
    // Gated by reset so the upstream never sees a pop while we are held in reset.
    capture = i_rstn & ~bus.set_empty & ~i_flush &
              ((state_q == StIdle) | (accept & last_q));
    if ((i_lane_cnt == '0) || (i_lane_cnt > CNT_W'(N))) begin
      eff_cnt = CNT_W'(N);
    end else begin
      eff_cnt = i_lane_cnt;
    end
    emit_nxt = emit_q + CNT_W'(1);
    last_nxt = (emit_nxt == (eff_q - CNT_W'(1)));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q    <= StIdle;
      sreg_q     <= '0;
      eff_q      <= '0;
      emit_q     <= '0;
      idx_q      <= '0;
      msb_q      <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      set_cnt_q  <= '0;
      lane_cnt_q <= '0;
    end else begin
      if (accept) begin
        lane_cnt_q <= lane_cnt_q + 16'd1;
      end
      if (capture) begin
        state_q   <= StActive;
        sreg_q    <= bus.set_data;
        eff_q     <= eff_cnt;
        emit_q    <= '0;
        idx_q     <= i_msb_first ? IDX_W'(N - 1) : '0;
        msb_q     <= i_msb_first;
        valid_q   <= 1'b1;
        last_q    <= (eff_cnt == CNT_W'(1));
        set_cnt_q <= set_cnt_q + 16'd1;
      end else if (i_flush) begin
        state_q <= StIdle;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end else if (accept) begin
        if (last_q) begin
          state_q <= StIdle;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end else begin
          // The head lane always sits at the end the emit order starts from.
          sreg_q <= msb_q ? (sreg_q << LANE_W) : (sreg_q >> LANE_W);
          idx_q  <= msb_q ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));
          emit_q <= emit_nxt;
          last_q <= last_nxt;
        end
      end
    end
  end

  always_comb begin
    bus.set_rd_en  = capture;
    bus.lane_valid = valid_q;
    bus.lane_data  = msb_q ? sreg_q[(N-1)*LANE_W +: LANE_W] : sreg_q[LANE_W-1:0];
    bus.lane_idx   = idx_q;
    bus.lane_last  = last_q;
    o_busy         = (state_q == StActive);
    o_set_count    = set_cnt_q;
    o_lane_count   = lane_cnt_q;
  end

endmodule
